// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: buffers one decoded pair, issues in order to even/odd pipes once hazards clear.
// Issue no earlier than the cycle after accept; fetch_ready drops while buffered slots remain blocked.
module issue_scheduler #(
  parameter int ADDR_W = 7,
  parameter int NREG   = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic              s0_pipe,
  input  logic [ADDR_W-1:0] s0_ra,
  input  logic [ADDR_W-1:0] s0_rb,
  input  logic [ADDR_W-1:0] s0_rt,
  input  logic              s0_wr,
  input  logic              s1_valid,
  input  logic              s1_pipe,
  input  logic [ADDR_W-1:0] s1_ra,
  input  logic [ADDR_W-1:0] s1_rb,
  input  logic [ADDR_W-1:0] s1_rt,
  input  logic              s1_wr,
  input  logic              wb_even_valid,
  input  logic [ADDR_W-1:0] wb_even_addr,
  input  logic              wb_odd_valid,
  input  logic [ADDR_W-1:0] wb_odd_addr,
  input  logic              flush,
  output logic              iss_even,
  output logic              iss_odd,
  output logic              iss_even_slot,
  output logic              iss_odd_slot,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, PAIR, SLOT1} state_t;

  typedef struct packed {
    logic              pipe;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rt;
    logic              wr;
  } slot_t;

  state_t            state_q, state_d;
  slot_t             b0_q, b1_q;
  logic              b1_valid_q;
  logic [NREG-1:0]   sb_q, sb_d;
  logic [NREG-1:0]   wbe_mask, wbo_mask, busy_vec;
  logic              rdy0, rdy1, dep1, iss0, iss1, all_done, accept;

  // Same-cycle writebacks are bypassed out of the busy view; r0 is hardwired free.
  always_comb begin
    wbe_mask = '0;
    wbo_mask = '0;
    if (wb_even_valid) wbe_mask[wb_even_addr] = 1'b1;
    if (wb_odd_valid)  wbo_mask[wb_odd_addr]  = 1'b1;
    busy_vec    = sb_q & ~wbe_mask & ~wbo_mask;
    busy_vec[0] = 1'b0;
  end

  assign rdy0 = !busy_vec[b0_q.ra] && !busy_vec[b0_q.rb] && !(b0_q.wr && busy_vec[b0_q.rt]);
  assign rdy1 = !busy_vec[b1_q.ra] && !busy_vec[b1_q.rb] && !(b1_q.wr && busy_vec[b1_q.rt]);
  assign dep1 = b0_q.wr && (b0_q.rt != '0) &&
                ((b1_q.ra == b0_q.rt) || (b1_q.rb == b0_q.rt) || (b1_q.wr && (b1_q.rt == b0_q.rt)));

  assign iss0 = !flush && (state_q == PAIR) && rdy0;
  assign iss1 = !flush && rdy1 &&
                ((state_q == SLOT1) ||
                 ((state_q == PAIR) && b1_valid_q && iss0 && (b1_q.pipe != b0_q.pipe) && !dep1));

  assign all_done = (state_q == EMPTY) ||
                    ((state_q == PAIR) && iss0 && (!b1_valid_q || iss1)) ||
                    ((state_q == SLOT1) && iss1);

  assign fetch_ready   = !reset && !flush && all_done;
  assign accept        = fetch_valid && fetch_ready;
  assign iss_even      = !reset && ((iss0 && !b0_q.pipe) || (iss1 && !b1_q.pipe));
  assign iss_odd       = !reset && ((iss0 && b0_q.pipe) || (iss1 && b1_q.pipe));
  assign iss_even_slot = !reset && iss1 && !b1_q.pipe;
  assign iss_odd_slot  = !reset && iss1 && b1_q.pipe;
  assign stall         = !reset && (state_q != EMPTY) && !iss0 && !iss1;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = PAIR;
    end else begin
      case (state_q)
        PAIR:    if (iss0) state_d = (b1_valid_q && !iss1) ? SLOT1 : EMPTY;
        SLOT1:   if (iss1) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Set after clear so an issuing writer wins over a retiring writeback to the same register.
  always_comb begin
    sb_d = sb_q & ~wbe_mask & ~wbo_mask;
    if (iss0 && b0_q.wr && (b0_q.rt != '0)) sb_d[b0_q.rt] = 1'b1;
    if (iss1 && b1_q.wr && (b1_q.rt != '0)) sb_d[b1_q.rt] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      sb_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      b1_valid_q <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      if (accept) begin
        b0_q       <= '{pipe: s0_pipe, ra: s0_ra, rb: s0_rb, rt: s0_rt, wr: s0_wr};
        b1_q       <= '{pipe: s1_pipe, ra: s1_ra, rb: s1_rb, rt: s1_rt, wr: s1_wr};
        b1_valid_q <= s1_valid;
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed + random bench for issue_scheduler against an in-order instruction-queue reference model.
module tb_issue_scheduler;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       pipe;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rt;
    logic       wr;
    logic       slot;
  } ins_t;

  logic clk = 1'b0;
  logic reset, fetch_valid, fetch_ready;
  logic s0_pipe, s0_wr, s1_valid, s1_pipe, s1_wr;
  logic [6:0] s0_ra, s0_rb, s0_rt, s1_ra, s1_rb, s1_rt;
  logic wb_even_valid, wb_odd_valid, flush;
  logic [6:0] wb_even_addr, wb_odd_addr;
  logic iss_even, iss_odd, iss_even_slot, iss_odd_slot, stall;
  logic [CNT_W-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  ins_t q[$];
  bit pend[128];
  int cnt = 0;
  ins_t NONE;

  always #5 clk = ~clk;

  issue_scheduler #(.ADDR_W(7), .NREG(128), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .s0_pipe(s0_pipe), .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rt(s0_rt), .s0_wr(s0_wr),
    .s1_valid(s1_valid), .s1_pipe(s1_pipe), .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rt(s1_rt),
    .s1_wr(s1_wr), .wb_even_valid(wb_even_valid), .wb_even_addr(wb_even_addr),
    .wb_odd_valid(wb_odd_valid), .wb_odd_addr(wb_odd_addr), .flush(flush),
    .iss_even(iss_even), .iss_odd(iss_odd), .iss_even_slot(iss_even_slot),
    .iss_odd_slot(iss_odd_slot), .stall(stall), .stall_cnt(stall_cnt)
  );

  function automatic ins_t mk(input logic p, input logic [6:0] ra, input logic [6:0] rb,
                              input logic [6:0] rt, input logic wr);
    ins_t i;
    i.pipe = p; i.ra = ra; i.rb = rb; i.rt = rt; i.wr = wr; i.slot = 1'b0;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    return mk(1'($urandom_range(0, 1)), 7'($urandom_range(0, 9)), 7'($urandom_range(0, 9)),
              7'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
  endfunction

  function automatic bit busy(input logic [6:0] r);
    if (r == 7'd0 || !pend[r]) return 1'b0;
    if (wb_even_valid && wb_even_addr == r) return 1'b0;
    if (wb_odd_valid && wb_odd_addr == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit ready(input ins_t i);
    return !busy(i.ra) && !busy(i.rb) && !(i.wr && busy(i.rt));
  endfunction

  function automatic bit depends(input ins_t younger, input ins_t older);
    if (!older.wr || older.rt == 7'd0) return 1'b0;
    return younger.ra == older.rt || younger.rb == older.rt ||
           (younger.wr && younger.rt == older.rt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic fv, input ins_t a, input logic s1v, input ins_t b,
                      input logic wev, input logic [6:0] wea, input logic wov,
                      input logic [6:0] woa, input logic fl, input logic rst);
    int n;
    logic ee, eo, ees, eos, efr, est;
    int ecnt;
    @(negedge clk);
    reset = rst; fetch_valid = fv; flush = fl;
    s0_pipe = a.pipe; s0_ra = a.ra; s0_rb = a.rb; s0_rt = a.rt; s0_wr = a.wr;
    s1_valid = s1v; s1_pipe = b.pipe; s1_ra = b.ra; s1_rb = b.rb; s1_rt = b.rt; s1_wr = b.wr;
    wb_even_valid = wev; wb_even_addr = wea; wb_odd_valid = wov; wb_odd_addr = woa;
    #1;
    n = 0; ee = 0; eo = 0; ees = 0; eos = 0;
    if (!rst && !fl && q.size() > 0 && ready(q[0])) begin
      n = 1;
      if (q[0].pipe) begin eo = 1; eos = q[0].slot; end
      else begin ee = 1; ees = q[0].slot; end
      if (q.size() > 1 && q[1].pipe != q[0].pipe && ready(q[1]) && !depends(q[1], q[0])) begin
        n = 2;
        if (q[1].pipe) begin eo = 1; eos = 1; end
        else begin ee = 1; ees = 1; end
      end
    end
    efr  = !rst && !fl && (q.size() == n);
    est  = !rst && q.size() > 0 && n == 0;
    ecnt = rst ? 0 : cnt;
    chk("iss_even", 32'(iss_even), 32'(ee));
    chk("iss_odd", 32'(iss_odd), 32'(eo));
    chk("iss_even_slot", 32'(iss_even_slot), 32'(ees));
    chk("iss_odd_slot", 32'(iss_odd_slot), 32'(eos));
    chk("fetch_ready", 32'(fetch_ready), 32'(efr));
    chk("stall", 32'(stall), 32'(est));
    chk("stall_cnt", 32'(stall_cnt), 32'(ecnt));
    @(posedge clk);
    if (rst) begin
      q.delete();
      foreach (pend[k]) pend[k] = 1'b0;
      cnt = 0;
    end else begin
      if (wev) pend[wea] = 1'b0;
      if (wov) pend[woa] = 1'b0;
      for (int k = 0; k < n; k++) if (q[k].wr && q[k].rt != 7'd0) pend[q[k].rt] = 1'b1;
      if (est && cnt < CMAX) cnt++;
      for (int k = 0; k < n; k++) void'(q.pop_front());
      if (fl) q.delete();
      if (fv && efr) begin
        a.slot = 1'b0;
        q.push_back(a);
        if (s1v) begin
          b.slot = 1'b1;
          q.push_back(b);
        end
      end
    end
  endtask

  task automatic idle();
    step(0, NONE, 0, NONE, 0, 7'd0, 0, 7'd0, 0, 0);
  endtask

  task automatic send(input ins_t a, input logic s1v, input ins_t b);
    step(1, a, s1v, b, 0, 7'd0, 0, 7'd0, 0, 0);
  endtask

  task automatic wb(input logic wev, input logic [6:0] wea, input logic wov, input logic [6:0] woa);
    step(0, NONE, 0, NONE, wev, wea, wov, woa, 0, 0);
  endtask

  initial begin
    NONE = mk(0, 7'd0, 7'd0, 7'd0, 0);
    reset = 1'b1; fetch_valid = 0; flush = 0; s1_valid = 0;
    s0_pipe = 0; s0_ra = 0; s0_rb = 0; s0_rt = 0; s0_wr = 0;
    s1_pipe = 0; s1_ra = 0; s1_rb = 0; s1_rt = 0; s1_wr = 0;
    wb_even_valid = 0; wb_even_addr = 0; wb_odd_valid = 0; wb_odd_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("reset_iss", 32'({iss_even, iss_odd, iss_even_slot, iss_odd_slot}), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    idle();

    // Independent even/odd pair issues together, then consumers of r5/r6 wait for writeback.
    send(mk(0, 7'd1, 7'd2, 7'd5, 1), 1, mk(1, 7'd3, 7'd4, 7'd6, 1));
    idle();
    send(mk(0, 7'd5, 7'd6, 7'd0, 0), 0, NONE);
    idle();
    wb(1, 7'd5, 1, 7'd6);
    idle();

    // Intra-pair RAW holds slot1 in SLOT1 until the writeback bypass frees r5.
    send(mk(0, 7'd1, 7'd1, 7'd5, 1), 1, mk(1, 7'd5, 7'd2, 7'd8, 1));
    idle();
    idle();
    wb(1, 7'd5, 0, 7'd0);
    wb(0, 7'd0, 1, 7'd8);

    // Same-pipe pair serialises; a new pair is accepted as slot1 leaves.
    send(mk(0, 7'd1, 7'd2, 7'd0, 0), 1, mk(0, 7'd3, 7'd4, 7'd0, 0));
    idle();
    send(mk(1, 7'd1, 7'd1, 7'd10, 1), 0, NONE);
    idle();
    wb(0, 7'd0, 1, 7'd10);

    // Busy source stalls for four cycles.
    send(mk(0, 7'd0, 7'd0, 7'd9, 1), 0, NONE);
    idle();
    send(mk(0, 7'd9, 7'd0, 7'd0, 0), 0, NONE);
    repeat (4) idle();
    wb(0, 7'd0, 1, 7'd9);

    // Set beats clear on r7; rt=0 never marks busy.
    send(mk(1, 7'd0, 7'd0, 7'd7, 1), 0, NONE);
    wb(0, 7'd0, 1, 7'd7);
    send(mk(0, 7'd7, 7'd0, 7'd0, 0), 0, NONE);
    idle();
    idle();
    wb(1, 7'd7, 0, 7'd0);
    send(mk(0, 7'd0, 7'd0, 7'd0, 1), 1, mk(1, 7'd0, 7'd0, 7'd0, 1));
    idle();
    send(mk(0, 7'd0, 7'd0, 7'd0, 0), 0, NONE);
    idle();

    // Flush in SLOT1, then reset in the middle of a blocked pair.
    send(mk(1, 7'd1, 7'd2, 7'd3, 1), 1, mk(1, 7'd4, 7'd4, 7'd0, 0));
    idle();
    step(0, NONE, 0, NONE, 0, 7'd0, 0, 7'd0, 1, 0);
    idle();
    send(mk(0, 7'd3, 7'd0, 7'd0, 0), 0, NONE);
    wb(0, 7'd0, 1, 7'd3);
    send(mk(0, 7'd0, 7'd0, 7'd11, 1), 0, NONE);
    idle();
    send(mk(0, 7'd11, 7'd0, 7'd0, 0), 1, mk(1, 7'd1, 7'd0, 7'd0, 0));
    idle();
    step(0, NONE, 0, NONE, 0, 7'd0, 0, 7'd0, 0, 1);
    step(0, NONE, 0, NONE, 0, 7'd0, 0, 7'd0, 0, 1);
    send(mk(0, 7'd11, 7'd0, 7'd0, 0), 0, NONE);
    idle();

    // Counter saturation.
    send(mk(1, 7'd0, 7'd0, 7'd12, 1), 0, NONE);
    idle();
    send(mk(0, 7'd12, 7'd0, 7'd0, 0), 0, NONE);
    repeat (70) idle();
    wb(1, 7'd12, 0, 7'd0);
    step(0, NONE, 0, NONE, 0, 7'd0, 0, 7'd0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rnd_ins(), 1'($urandom_range(0, 1)), rnd_ins(),
           1'($urandom_range(0, 2) == 0), 7'($urandom_range(0, 9)),
           1'($urandom_range(0, 2) == 0), 7'($urandom_range(0, 9)),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
